i2c_slave_regfile: RTL and testbench
====================================

// Module: i2c_slave_regfile
// PURPOSE
//  I2C target (slave) holding a small byte-addressed register file. Sits on the far side of the bus from the soft
//  I2C master: consumes its START/addr/reg-pointer/data/STOP sequences, ACKs its own address and returns register
//  contents on reads. Runs on the system clock; SCL/SDA are oversampled, and the block never drives SCL.
// PARAMETERS
//  DEV_ADDR  7'h66  7-bit device address answered; any other address is NACKed (SDA left released)
//  ADDR_W    4      register pointer width; file depth = 2**ADDR_W bytes
//  HOLD_CYC  8      clk_i cycles after a synced SCL fall before SDA is changed (data hold time)
// PORTS
//  clk_i        in   1        system clock
//  rst_i        in   1        synchronous, active-high reset
//  scl_i        in   1        bus SCL (asynchronous)
//  sda_i        in   1        bus SDA (asynchronous)
//  sda_o        out  1        SDA drive value; constant 0 (open-drain emulation)
//  sda_oe_o     out  1        1 = pull SDA low; 0 = release
//  reg_raddr_i  in   ADDR_W   host-side read address
//  reg_rdata_o  out  8        host-side read data, combinational from file[reg_raddr_i]
//  wr_strb_o    out  1        1-cycle pulse when a bus write commits a byte
//  wr_addr_o    out  ADDR_W   register written (valid with wr_strb_o)
//  wr_data_o    out  8        byte written (valid with wr_strb_o)
//  busy_o       out  1        1 between an accepted START and the following STOP
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high. On rst_i: sda_oe_o=0, sda_o=0, wr_strb_o=0,
//   busy_o=0, FSM=IDLE, pointer=0, file cleared to 8'h00, sync flops=1. Reset mid-transfer releases SDA next edge.
//  Input stage: scl_i/sda_i each through 2-flop sync plus 1 history flop; rise/fall flags from synced vs history.
//   START = SDA fall while SCL high; STOP = SDA rise while SCL high. Both override any state, every cycle.
//  Data sampled on synced SCL rise; slave changes sda_oe_o exactly HOLD_CYC cycles after synced SCL fall.
//  FSM: IDLE -> (START) ADDR: shift 8 bits MSB first. Byte done: addr==DEV_ADDR -> ACK_A (pull low one SCL
//   period) else IGNORE (released until START/STOP). ACK_A: R/W=0 -> PTR; R/W=1 -> load file[ptr], RDATA.
//   PTR: 8 bits -> ptr <= byte[ADDR_W-1:0] (upper bits dropped), ACK -> WDATA.
//   WDATA: 8 bits -> file[ptr] <= byte, wr_strb_o pulse same cycle as file update, ptr <= ptr+1 (wraps at
//   2**ADDR_W), ACK -> WDATA. Repeated START in PTR/WDATA -> ADDR with ptr retained (combined read).
//   RDATA: drive bit (oe=~bit) for 8 SCL periods, then release -> MACK: sample master ACK on SCL rise;
//   ptr <= ptr+1 either way; ACK (0) -> load next byte, RDATA; NACK (1) -> IGNORE.
//  STOP in any state -> IDLE, release SDA, busy_o=0; partial byte discarded, no wr_strb_o.
//  START mid-byte (any state) -> ADDR, bit counter cleared, SDA released the same cycle.
//  Host reg_raddr_i read and bus write same cycle/same address: reg_rdata_o shows old value until next cycle.
//  Slave never stretches SCL; ACK bit is pulled low before the master's SCL rise mid-bit (HOLD_CYC < quarter SCL).
// STRUCTURE
//  i2c_pkg: FSM state enum, I2C_DEV_ADDR_DEFAULT=7'h66, ACK=1'b0 / NACK=1'b1 constants.
//  Sub-module i2c_line_sync: 2FF sync + edge detect + START/STOP flags (reusable by the master side later).
//  Top: FSM, 3-bit bit counter, 8-bit shift reg, pointer, register file, HOLD_CYC down-counter.
// TESTING (bench pairs with soft_i2c master model, SCL period 128 clk_i)
//  1 Write 0x66/W, reg 0x01, data 0xA5, STOP -> ACK on all 3 bytes; wr_strb_o once, addr=1, data=A5; file[1]=A5
//  2 Then 0x66/W, reg 0x01, rSTART 0x66/R, master NACK -> bus byte = 0xA5; SDA released; ptr=2 after
//  3 Address 0x1A/W -> no ACK (sda_oe_o stays 0 whole transfer); master NACK path -> STOP; file unchanged
//  4 Burst write reg 0x0F, data 11,22 -> file[F]=11, file[0]=22 (pointer wrap); two wr_strb_o pulses
//  5 Burst read from reg 0x0E with master ACK x2, NACK on 3rd -> bytes file[E],file[F],file[0]; then IGNORE
//  6 STOP after 4 data bits of a write; rst_i pulse mid-RDATA -> no wr_strb_o, file unchanged; oe=0 next cycle

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus-level constants.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK_A,
      ST_PTR,
      ST_ACK_P,
      ST_WDATA,
      ST_ACK_W,
      ST_RDATA,
      ST_MACK,
      ST_IGNORE
   } i2c_state_e;

   localparam logic [6:0] I2C_DEV_ADDR_DEFAULT = 7'h66;
   localparam logic       ACK  = 1'b0;
   localparam logic       NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with edge detection and START/STOP condition flags.
module i2c_line_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_sync_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   // [0],[1] form the synchronizer, [2] is the history flop for edge detection
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[1:0], scl_i};
         sda_q <= {sda_q[1:0], sda_i};
      end
   end

   assign sda_sync_o = sda_q[1];
   assign scl_rise_o = scl_q[1] & ~scl_q[2];
   assign scl_fall_o = ~scl_q[1] & scl_q[2];
   assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
   assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-addressed register file; oversampled bus, never stretches SCL.
module i2c_slave_regfile
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = I2C_DEV_ADDR_DEFAULT,
   parameter int          ADDR_W   = 4,
   parameter int          HOLD_CYC = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              sda_o,
   output logic              sda_oe_o,
   input  logic [ADDR_W-1:0] reg_raddr_i,
   output logic [7:0]        reg_rdata_o,
   output logic              wr_strb_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [7:0]        wr_data_o,
   output logic              busy_o
);

   localparam int DEPTH  = 2**ADDR_W;
   localparam int HOLD_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

   logic sda_s, scl_rise, scl_fall, start, stop;

   i2c_line_sync u_sync (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .sda_sync_o (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start),
      .stop_o     (stop)
   );

   i2c_state_e        state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        tx_q, tx_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              done_q, done_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              pend_q, pend_d;
   logic              oe_nxt_q, oe_nxt_d;
   logic              oe_q, oe_d;
   logic              sched_en, sched_val, file_we;
   logic [7:0]        wr_byte;

   logic [7:0]        file_q [DEPTH];
   logic              wr_strb_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;

   assign wr_byte = {shift_q[6:0], sda_s};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_q      <= '0;
         ptr_q     <= '0;
         done_q    <= 1'b0;
         hold_q    <= '0;
         pend_q    <= 1'b0;
         oe_nxt_q  <= 1'b0;
         oe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         ptr_q     <= ptr_d;
         done_q    <= done_d;
         hold_q    <= hold_d;
         pend_q    <= pend_d;
         oe_nxt_q  <= oe_nxt_d;
         oe_q      <= oe_d;
      end
   end

   // Bits are sampled on SCL rise; byte boundaries and SDA changes are taken on SCL fall.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      ptr_d     = ptr_q;
      done_d    = done_q;
      hold_d    = hold_q;
      pend_d    = pend_q;
      oe_nxt_d  = oe_nxt_q;
      oe_d      = oe_q;
      sched_en  = 1'b0;
      sched_val = 1'b0;
      file_we   = 1'b0;

      if (pend_q) begin
         if (hold_q == '0) begin
            oe_d   = oe_nxt_q;
            pend_d = 1'b0;
         end else begin
            hold_d = hold_q - 1'b1;
         end
      end

      if (stop || start) begin
         state_d   = stop ? ST_IDLE : ST_ADDR;
         oe_d      = 1'b0;
         pend_d    = 1'b0;
         bit_cnt_d = '0;
         done_d    = 1'b0;
      end else if (scl_rise) begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               shift_d   = wr_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  done_d = 1'b1;
                  if (state_q == ST_PTR) ptr_d = wr_byte[ADDR_W-1:0];
                  if (state_q == ST_WDATA) begin
                     file_we = 1'b1;
                     ptr_d   = ptr_q + 1'b1;
                  end
               end
            end
            ST_RDATA: begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) done_d = 1'b1;
            end
            ST_MACK: begin
               shift_d = wr_byte;
               ptr_d   = ptr_q + 1'b1;
            end
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state_q)
            ST_ADDR: if (done_q) begin
               done_d = 1'b0;
               if (shift_q[7:1] == DEV_ADDR) begin
                  state_d   = ST_ACK_A;
                  sched_en  = 1'b1;
                  sched_val = ~ACK;
               end else begin
                  state_d = ST_IGNORE;
               end
            end
            ST_PTR, ST_WDATA: if (done_q) begin
               done_d    = 1'b0;
               state_d   = (state_q == ST_PTR) ? ST_ACK_P : ST_ACK_W;
               sched_en  = 1'b1;
               sched_val = ~ACK;
            end
            ST_ACK_A: begin
               sched_en = 1'b1;
               if (shift_q[0]) begin
                  state_d   = ST_RDATA;
                  tx_d      = file_q[ptr_q];
                  sched_val = ~file_q[ptr_q][7];
               end else begin
                  state_d = ST_PTR;
               end
            end
            ST_ACK_P, ST_ACK_W: begin
               state_d  = ST_WDATA;
               sched_en = 1'b1;
            end
            ST_RDATA: begin
               sched_en = 1'b1;
               if (done_q) begin
                  done_d  = 1'b0;
                  state_d = ST_MACK;
               end else begin
                  tx_d      = {tx_q[6:0], 1'b0};
                  sched_val = ~tx_q[6];
               end
            end
            ST_MACK: begin
               if (shift_q[0] == ACK) begin
                  state_d   = ST_RDATA;
                  tx_d      = file_q[ptr_q];
                  sched_en  = 1'b1;
                  sched_val = ~file_q[ptr_q][7];
               end else begin
                  state_d = ST_IGNORE;
               end
            end
            default: ;
         endcase
      end

      // The synced fall is already one cycle old here, hence HOLD_CYC-2 remaining waits.
      if (sched_en) begin
         pend_d   = 1'b1;
         hold_d   = HOLD_W'(HOLD_CYC - 2);
         oe_nxt_d = sched_val;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the register file is cleared on reset, so it is built from flops rather than a RAM.
         for (int i = 0; i < DEPTH; i++) file_q[i] <= 8'h00;
         wr_strb_q <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_strb_q <= file_we;
         if (file_we) begin
            file_q[ptr_q] <= wr_byte;
            wr_addr_q     <= ptr_q;
            wr_data_q     <= wr_byte;
         end
      end
   end

   assign sda_o       = 1'b0;
   assign sda_oe_o    = oe_q;
   assign reg_rdata_o = file_q[reg_raddr_i];
   assign wr_strb_o   = wr_strb_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;
   assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, reference register model, write/read scoreboards.
module tb_i2c_slave_regfile;
   import i2c_pkg::*;

   localparam int         ADDR_W   = 4;
   localparam int         HOLD_CYC = 8;
   localparam int         QTR      = 32;   // quarter of a 128-clock SCL period
   localparam logic [6:0] DEV      = 7'h66;

   logic              clk   = 1'b0;
   logic              rst_i = 1'b1;
   logic              scl   = 1'b1;
   logic              sda_m = 1'b1;
   logic              sda_bus;
   logic              sda_o, sda_oe_o, wr_strb_o, busy_o;
   logic [ADDR_W-1:0] reg_raddr_i = '0;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [7:0]        reg_rdata_o, wr_data_o;

   int total = 0;
   int bad   = 0;

   logic [7:0]        model_mem [2**ADDR_W];
   logic [ADDR_W-1:0] model_ptr;
   logic [11:0]       exp_wr_q [$];
   logic [7:0]        exp_rd_q [$];

   int   since_fall = 0;
   int   oe_lat     = -1;
   logic scl_prev   = 1'b1;
   logic oe_prev    = 1'b0;
   logic oe_seen    = 1'b0;

   assign sda_bus = sda_m & ~sda_oe_o;

   always #5 clk = ~clk;

   i2c_slave_regfile #(
      .DEV_ADDR (DEV),
      .ADDR_W   (ADDR_W),
      .HOLD_CYC (HOLD_CYC)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .scl_i       (scl),
      .sda_i       (sda_bus),
      .sda_o       (sda_o),
      .sda_oe_o    (sda_oe_o),
      .reg_raddr_i (reg_raddr_i),
      .reg_rdata_o (reg_rdata_o),
      .wr_strb_o   (wr_strb_o),
      .wr_addr_o   (wr_addr_o),
      .wr_data_o   (wr_data_o),
      .busy_o      (busy_o)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Clocks since the master last dropped SCL (0 on the first edge after the fall).
   always @(posedge clk) begin
      since_fall <= (scl_prev && !scl) ? 0 : since_fall + 1;
      scl_prev   <= scl;
   end

   always @(negedge clk) begin
      if (sda_oe_o && !oe_prev) oe_lat <= since_fall;
      oe_prev <= sda_oe_o;
      if (sda_oe_o) oe_seen <= 1'b1;
      if (wr_strb_o) begin
         if (exp_wr_q.size() == 0) check("wr_strb_unexpected", 32'(wr_strb_o), 32'd0);
         else check("wr_commit", {wr_addr_o, wr_data_o}, exp_wr_q.pop_front());
      end
   end

   task automatic qtr();
      repeat (QTR) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; scl = 1'b1; qtr();
      sda_m = 1'b0; qtr();
      scl = 1'b0; qtr();
   endtask

   task automatic i2c_rstart();
      sda_m = 1'b1; qtr();
      scl = 1'b1; qtr();
      sda_m = 1'b0; qtr();
      scl = 1'b0; qtr();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; qtr();
      scl = 1'b1; qtr();
      sda_m = 1'b1; qtr();
   endtask

   task automatic write_bit(input logic b);
      sda_m = b; qtr();
      scl = 1'b1; qtr(); qtr();
      scl = 1'b0; qtr();
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; qtr();
      scl = 1'b1; qtr();
      b = sda_bus; qtr();
      scl = 1'b0; qtr();
   endtask

   task automatic send(input logic [7:0] d, input logic exp_ack, input string tag);
      logic a;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(a);
      check(tag, 32'(a), 32'(exp_ack));
   endtask

   task automatic set_ptr(input logic [ADDR_W-1:0] p);
      send(8'(p), ACK, "ack_ptr");
      model_ptr = p;
   endtask

   task automatic wr_data(input logic [7:0] d);
      exp_wr_q.push_back({model_ptr, d});
      model_mem[model_ptr] = d;
      model_ptr = model_ptr + 1'b1;
      send(d, ACK, "ack_data");
   endtask

   task automatic rd_data(input logic master_ack);
      logic [7:0] d;
      exp_rd_q.push_back(model_mem[model_ptr]);
      model_ptr = model_ptr + 1'b1;
      for (int i = 7; i >= 0; i--) read_bit(d[i]);
      write_bit(master_ack);
      check("rd_data", 32'(d), 32'(exp_rd_q.pop_front()));
   endtask

   task automatic check_file();
      for (int i = 0; i < 2**ADDR_W; i++) begin
         reg_raddr_i = ADDR_W'(i);
         #1;
         check($sformatf("file[%0d]", i), 32'(reg_rdata_o), 32'(model_mem[i]));
      end
   endtask

   task automatic check_idle(input string tag);
      repeat (4) @(negedge clk);
      check({tag, "_busy"}, 32'(busy_o), 32'd0);
      check({tag, "_oe"}, 32'(sda_oe_o), 32'd0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2**ADDR_W; i++) model_mem[i] = 8'h00;
      model_ptr = '0;
   endtask

   initial begin
      logic b;
      model_reset();
      repeat (5) @(negedge clk);
      check("rst_oe", 32'(sda_oe_o), 32'd0);
      check("rst_sda_o", 32'(sda_o), 32'd0);
      check("rst_strb", 32'(wr_strb_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      rst_i = 1'b0;
      repeat (4) @(negedge clk);
      check_file();

      // single write, plus ACK hold timing (synced fall lands at count 1)
      i2c_start();
      check("busy_start", 32'(busy_o), 32'd1);
      oe_lat = -1;
      send({DEV, 1'b0}, ACK, "ack_addr_w");
      check("ack_hold_lat", 32'(oe_lat), 32'(HOLD_CYC + 1));
      set_ptr(4'h1);
      wr_data(8'hA5);
      i2c_stop();
      check_idle("t1");
      check_file();

      // combined read of one byte
      i2c_start();
      send({DEV, 1'b0}, ACK, "ack_addr_w");
      set_ptr(4'h1);
      i2c_rstart();
      send({DEV, 1'b1}, ACK, "ack_addr_r");
      rd_data(NACK);
      i2c_stop();
      check_idle("t2");

      // foreign address: never pulled low
      oe_seen = 1'b0;
      i2c_start();
      send({7'h1A, 1'b0}, NACK, "nack_addr");
      i2c_stop();
      check("foreign_oe_seen", 32'(oe_seen), 32'd0);
      check_idle("t3");
      check_file();

      // burst write across the pointer wrap, then a current-address read
      i2c_start();
      send({DEV, 1'b0}, ACK, "ack_addr_w");
      set_ptr(4'hF);
      wr_data(8'h11);
      wr_data(8'h22);
      i2c_stop();
      check_idle("t4");
      check_file();
      i2c_start();
      send({DEV, 1'b1}, ACK, "ack_addr_r");
      rd_data(NACK);
      i2c_stop();

      // burst read across the wrap, then extra clocks must stay released
      i2c_start();
      send({DEV, 1'b0}, ACK, "ack_addr_w");
      set_ptr(4'hE);
      i2c_rstart();
      send({DEV, 1'b1}, ACK, "ack_addr_r");
      rd_data(ACK);
      rd_data(ACK);
      rd_data(NACK);
      oe_seen = 1'b0;
      read_bit(b);
      read_bit(b);
      check("ignore_oe_seen", 32'(oe_seen), 32'd0);
      i2c_stop();
      check_idle("t5");

      // STOP after a partial data byte: nothing commits
      i2c_start();
      send({DEV, 1'b0}, ACK, "ack_addr_w");
      set_ptr(4'h3);
      for (int i = 0; i < 4; i++) write_bit(1'b1);
      i2c_stop();
      check_idle("t6_stop");
      check_file();

      // reset while the slave drives a read bit (file[0]=22, MSB 0 -> pulled low)
      i2c_start();
      send({DEV, 1'b0}, ACK, "ack_addr_w");
      set_ptr(4'h0);
      i2c_rstart();
      send({DEV, 1'b1}, ACK, "ack_addr_r");
      sda_m = 1'b1; qtr();
      check("rd_drive_oe", 32'(sda_oe_o), 32'd1);
      rst_i = 1'b1;
      @(negedge clk);
      check("rst_mid_oe", 32'(sda_oe_o), 32'd0);
      check("rst_mid_busy", 32'(busy_o), 32'd0);
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      model_reset();
      scl = 1'b1; sda_m = 1'b1; qtr();
      check_file();

      // still functional after the reset
      i2c_start();
      send({DEV, 1'b0}, ACK, "ack_addr_w");
      set_ptr(4'h5);
      wr_data(8'h5A);
      i2c_stop();
      check_idle("t7");
      check_file();

      check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
